lane_spawner: RTL
=================

# lane_spawner

Level generator that drives the spawn interface of every `lane` instance in the playfield. On each `Start` it walks the lanes in order. For every lane it draws a pseudo-random direction, car type, car count and car speed, scaled by the current difficulty `Level`. It presents those values on a shared parameter bus, then pulses that lane's one-hot `SpawnEnable` bit so the lane and its cars latch them. It sits between the game-state FSM (which supplies `Start` and `Level`) and the array of lanes.

## Interface
- `LANES`, default 8: number of lanes driven; valid range 1..16.
- `SPAWN_HOLD`, default 2: cycles each `SpawnEnable` bit stays high; must be ≥1.
- `FrameClk`, in, 1: sole clock; all state updates on its rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Start`, in, 1: request to generate a new level; sampled only in IDLE.
- `Level`, in, 4: difficulty, 0..15; sampled at every SETUP entry.
- `Seed`, in, 16: LFSR seed; loaded while `Reset` is high.
- `SpawnEnable`, out, LANES: one-hot per-lane spawn strobe (bit i drives lane i).
- `Direction`, out, 1: 1 = cars face left.
- `CarType`, out, 2: sprite selector.
- `CarCount`, out, 3: lane count code 0..4 (0 = one car, 4 = five cars).
- `CarSpeed`, out, 3: 1..7 pixels/frame.
- `Busy`, out, 1: high from SETUP of lane 0 through GAP of the last lane.
- `Done`, out, 1: single-cycle pulse when all lanes have been spawned.

## Operation
- States: IDLE, SETUP, PULSE, GAP, DONE. A lane index `idx` (4 bit) counts 0..LANES-1.
- IDLE
  - `Start`=1 → SETUP with idx=0.
  - `Start` in any other state is ignored; it is not queued.
- SETUP (1 cycle)
  - On entry, register the parameter bus from the LFSR value `L` current at the transition edge:
    - `Direction` = `L[0]`
    - `CarType` = `L[2:1]`
    - `CarCount` = min(4, `L[4:3]` + (`Level` ≥ 4 ? 1 : 0))
    - `CarSpeed` = min(7, 1 + `L[7:6]` + `Level[3:1]`), computed in 4 bits and then saturated.
  - Next state: PULSE.
- PULSE (SPAWN_HOLD cycles)
  - `SpawnEnable[idx]`=1, all other bits 0.
  - The parameter bus is stable for the whole pulse and has been valid for 1 cycle before the rising edge of the strobe.
  - A hold counter counts the cycles.
- GAP (1 cycle)
  - `SpawnEnable`=0, bus held.
  - If idx=LANES-1 → DONE; else idx+1 → SETUP.
- DONE (1 cycle): `Done`=1, `Busy`=0 → IDLE.
- LFSR
  - 16-bit Galois, feedback mask 16'hB400 (shift right; when bit 0 is 1, XOR the mask in).
  - Advances every non-reset cycle in every state, so spawn timing affects the values drawn.
  - A seed of 16'h0000 is replaced by 16'hACE1 at load.
- Parameter bus holds its last values in IDLE/DONE until the next SETUP entry.
- Reset (any state, including mid-pulse), effective at the next edge:
  - State=IDLE, idx=0, hold counter=0.
  - All outputs 0: `SpawnEnable`, `Direction`, `CarType`, `CarCount`, `CarSpeed`, `Busy`, `Done`.
  - LFSR=`Seed` (after zero substitution).
  - A lane whose strobe is cut short by reset is not re-spawned.

## Timing
- `Start` sampled high at edge t. Lane i:
  - SETUP at cycle t+1+i·(SPAWN_HOLD+2).
  - PULSE on the following SPAWN_HOLD cycles.
  - One GAP cycle after the pulse.
- Defaults (LANES=8, SPAWN_HOLD=2):
  - Lane 0: SETUP t+1, `SpawnEnable[0]` high t+2..t+3, GAP t+4.
  - Lane 7: SETUP t+29, GAP t+32.
  - `Done` high at t+33; IDLE at t+34.
  - A new `Start` is accepted at t+34 at the earliest.
- `Busy` is registered: high t+1..t+32 inclusive.
- Never more than one `SpawnEnable` bit high.
- `SpawnEnable` is low for at least 2 cycles (GAP+SETUP) between consecutive lanes.

## Test plan
- **Reset values:** `Reset`=1 for 2 cycles with `Seed`=16'h1234, then released → all outputs 0, state IDLE, LFSR=16'h1234 on the first non-reset cycle.
- **Full sequence:** `Seed`=0, `Level`=0, `Start` pulse at t.
  - LFSR starts from 16'hACE1.
  - `SpawnEnable` one-hot walks 8'h01..8'h80, each bit high exactly 2 cycles at t+2+4i.
  - `Done` high only at t+33; `Busy` high t+1..t+32.
  - Bus values match a bit-exact LFSR model; `CarCount` ≤3 and `CarSpeed` 1..4.
- **Saturation:** `Level`=15 → every lane has `CarSpeed`=7 and `CarCount` in 1..4; `CarCount` never reads 5..7.
- **Ignored `Start`:** `Start` held high through the entire sequence → exactly one sequence runs; the next begins with SETUP at t+35, since `Start` is sampled in IDLE at t+34.
- **Mid-pulse reset:** assert `Reset` while `SpawnEnable[3]` is high → all outputs 0 at the next edge; no further strobes; after release, `Start` restarts at lane 0.
- **Parameter override:** `LANES`=3, `SPAWN_HOLD`=1 → 3-cycle lane period, `Done` at t+10, `SpawnEnable` width 3.

Source files
------------

// File: rtl/lane_spawner.sv
// Level generator: walks every lane on Start, drawing LFSR-based car parameters scaled by Level
// and strobing each lane's one-hot SpawnEnable bit while the shared parameter bus is stable.
module lane_spawner #(
    parameter int LANES      = 8,
    parameter int SPAWN_HOLD = 2
) (
    input  logic             FrameClk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Level,
    input  logic [15:0]      Seed,
    output logic [LANES-1:0] SpawnEnable,
    output logic             Direction,
    output logic [1:0]       CarType,
    output logic [2:0]       CarCount,
    output logic [2:0]       CarSpeed,
    output logic             Busy,
    output logic             Done
);

    localparam int HoldW = (SPAWN_HOLD > 1) ? $clog2(SPAWN_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(SPAWN_HOLD - 1);
    localparam logic [3:0] IdxLast = 4'(LANES - 1);
    localparam logic [15:0] LfsrMask = 16'hB400;
    localparam logic [15:0] SeedSubst = 16'hACE1;

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StGap, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [LANES-1:0]   se_d;
    logic               busy_d, done_d;
    logic               dir_d;
    logic [1:0]         type_d;
    logic [2:0]         count_d, speed_d;
    logic [2:0]         count_sum;
    logic [3:0]         speed_sum;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StSetup;
                    idx_d   = '0;
                end
            end
            StSetup: begin
                state_d = StPulse;
                hold_d  = '0;
            end
            StPulse: begin
                if (hold_q == HoldLast) begin
                    state_d = StGap;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StGap: begin
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    state_d = StSetup;
                    idx_d   = idx_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Galois LFSR, shift right; free-running so spawn timing perturbs the draws.
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);
    end

    always_comb begin
        count_sum = {1'b0, lfsr_q[4:3]} + {2'b00, (Level >= 4'd4)};
        speed_sum = 4'd1 + {2'b00, lfsr_q[7:6]} + {1'b0, Level[3:1]};
        dir_d     = Direction;
        type_d    = CarType;
        count_d   = CarCount;
        speed_d   = CarSpeed;
        // SETUP lasts one cycle, so state_d == StSetup marks every entry edge.
        if (state_d == StSetup) begin
            dir_d   = lfsr_q[0];
            type_d  = lfsr_q[2:1];
            count_d = (count_sum > 3'd4) ? 3'd4 : count_sum;
            speed_d = (speed_sum > 4'd7) ? 3'd7 : speed_sum[2:0];
        end
    end

    always_comb begin
        se_d = '0;
        for (int i = 0; i < LANES; i++) begin
            se_d[i] = (state_d == StPulse) && (idx_d == 4'(i));
        end
        busy_d = (state_d == StSetup) || (state_d == StPulse) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge FrameClk) begin
        if (Reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            hold_q      <= '0;
            lfsr_q      <= (Seed == 16'h0000) ? SeedSubst : Seed;
            SpawnEnable <= '0;
            Direction   <= 1'b0;
            CarType     <= '0;
            CarCount    <= '0;
            CarSpeed    <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            lfsr_q      <= lfsr_d;
            SpawnEnable <= se_d;
            Direction   <= dir_d;
            CarType     <= type_d;
            CarCount    <= count_d;
            CarSpeed    <= speed_d;
            Busy        <= busy_d;
            Done        <= done_d;
        end
    end

endmodule
